collision_detector: RTL
=======================

Name: collision_detector

Overview:
- Consumes the per-frame obstacle positions from the pterosaur and cactus draw stages, plus the dinosaur position.
- Decides when the dinosaur has been hit and drives the global Dead flag back into those stages and the game controller.
- Keeps the running score and the high score.
- Runs once per frame on frame_Clk, in front of the game-state controller.

Parameters:
DINO_W, 88, dinosaur sprite width in pixels
DINO_H, 94, dinosaur sprite height in pixels
PTERO_W, 92, pterosaur sprite width
PTERO_H, 80, pterosaur sprite height
HIT_MARGIN, 8, pixels trimmed from every edge of every box before the overlap test
CONFIRM_FRAMES, 2, consecutive overlapping frames required to declare a hit (valid range 1..15)
DEATH_HOLD, 30, frames spent in DEAD before Restart_Ready asserts
SCORE_DIV, 6, frames per score increment

Ports:
frame_Clk  in  1  frame-rate clock; all state updates on its rising edge
Reset  in  1  asynchronous, active-high
Game_State  in  2  00 start screen, 01 running, 10 game over, 11 treated as 00
Dino_PosX  in  32 signed  dinosaur top-left X
Dino_PosY  in  32 signed  dinosaur top-left Y
Ptero_PosX  in  32 signed  pterosaur top-left X
Ptero_PosY  in  32 signed  pterosaur top-left Y
pt_off  in  1  1 = pterosaur inactive; exclude it from the test
Cactus_PosX  in  32 signed  cactus top-left X
Cactus_PosY  in  32 signed  cactus top-left Y
Cactus_SizeX  in  32 signed  cactus width; value <= 0 means no cactus
Cactus_SizeY  in  32 signed  cactus height
Dead  out  1  registered hit flag
Hit_Type  out  2  00 none, 01 cactus, 10 pterosaur, 11 both; latched at hit
Restart_Ready  out  1  high once DEAD has lasted DEATH_HOLD frames
Score  out  16  current score, saturates at 16'hFFFF
Hi_Score  out  16  best score since Reset

Behaviour:
Reset values:
- State IDLE; Dead 0, Hit_Type 00, Restart_Ready 0, Score 0, Hi_Score 0.
- Internal counters hit_cnt, div_cnt and hold_cnt all 0.

Overlap test (combinational, signed 32-bit):
- Each box reduces to lo = pos + HIT_MARGIN and hi = pos + size - HIT_MARGIN.
- Two boxes overlap iff aXlo < bXhi && bXlo < aXhi && aYlo < bYhi && bYlo < aYhi. These are strict comparisons, so boxes that only touch at an edge do not overlap.
- ov_p = dino-vs-pterosaur overlap && !pt_off.
- ov_c = dino-vs-cactus overlap && Cactus_SizeX > 0.
- ov = ov_p | ov_c.
- Negative positions (obstacle partly off the left edge) are legal and must compare correctly.

State machine (IDLE, RUN, PENDING, DEAD), evaluated on each frame_Clk edge:
- IDLE:
  - Dead = 0, Restart_Ready = 0.
  - On Game_State == 01: go to RUN, clear Score, div_cnt, hit_cnt and Hit_Type.
- RUN:
  - If Game_State != 01: go to IDLE; Score is held.
  - Else if ov and CONFIRM_FRAMES == 1: go to DEAD.
  - Else if ov: go to PENDING with hit_cnt = 1.
  - Otherwise stay in RUN and advance the score.
- PENDING:
  - If Game_State != 01: go to IDLE.
  - Else if !ov: go to RUN with hit_cnt = 0. A miss only breaks the chain.
  - Else if hit_cnt + 1 == CONFIRM_FRAMES: go to DEAD.
  - Else increment hit_cnt.
  - The score keeps advancing while in PENDING.
- Entering DEAD (on the same edge):
  - Dead <= 1.
  - Hit_Type <= {ov_p, ov_c} sampled on the confirming frame.
  - Hi_Score <= max(Hi_Score, Score).
  - hold_cnt <= 0.
- DEAD:
  - Score is frozen and inputs are ignored except Game_State.
  - hold_cnt increments, saturating at DEATH_HOLD; Restart_Ready = (hold_cnt == DEATH_HOLD).
  - On Game_State == 00 or 11 with Restart_Ready = 1: go to IDLE with Dead <= 0.
  - Game_State == 00 with Restart_Ready = 0 is ignored.

Score:
- div_cnt counts 0..SCORE_DIV-1 in RUN and PENDING.
- On wrap, Score increments by 1, saturating at 16'hFFFF.

Latency:
- Dead rises on the edge that ends the CONFIRM_FRAMES-th consecutive overlapping frame.

Reset mid-operation:
- Asynchronous return to reset values from any state.
- Hi_Score is also cleared.

Test Plan:
1. Reset, Game_State = 01, dino at (100,300), pt_off = 1, Cactus_SizeX = 0, run 60 frames -> state stays RUN, Score = 10, Dead = 0.
2. Cactus box (150,310,50,90) overlapping the dino for 2 frames -> Dead rises on the 2nd edge, Hit_Type = 01, Hi_Score = Score at that edge.
3. Pterosaur overlapping for 1 frame, then clear, then overlapping for 1 frame (CONFIRM_FRAMES = 2) -> Dead stays 0, state returns to RUN in between.
4. Edge-touch case: cactus X such that after margins dinoXhi == cactusXlo -> no hit. Shift by 1 pixel, held for 2 frames -> Dead = 1.
5. In DEAD, Game_State = 00 at frame 10 -> ignored. Restart_Ready rises after 30 frames; Game_State = 00 then -> IDLE, Dead = 0; next Game_State = 01 -> Score = 0, Hi_Score retained.
6. Assert Reset during PENDING -> all outputs return to 0 immediately, without waiting for a clock edge. Pterosaur at X = -50 overlapping a dino at X = 0 -> hit detected.

Source files
------------

// File: rtl/collision_detector_if.sv
// Per-frame obstacle/dinosaur geometry in, hit status and scores out.
// The draw stages and testbench drive the master side; the collision detector is the slave.
interface collision_detector_if;
  logic [1:0]         Game_State;
  logic signed [31:0] Dino_PosX;
  logic signed [31:0] Dino_PosY;
  logic signed [31:0] Ptero_PosX;
  logic signed [31:0] Ptero_PosY;
  logic               pt_off;
  logic signed [31:0] Cactus_PosX;
  logic signed [31:0] Cactus_PosY;
  logic signed [31:0] Cactus_SizeX;
  logic signed [31:0] Cactus_SizeY;
  logic               Dead;
  logic [1:0]         Hit_Type;
  logic               Restart_Ready;
  logic [15:0]        Score;
  logic [15:0]        Hi_Score;

  modport master (
    output Game_State, Dino_PosX, Dino_PosY, Ptero_PosX, Ptero_PosY, pt_off,
           Cactus_PosX, Cactus_PosY, Cactus_SizeX, Cactus_SizeY,
    input  Dead, Hit_Type, Restart_Ready, Score, Hi_Score
  );

  modport slave (
    input  Game_State, Dino_PosX, Dino_PosY, Ptero_PosX, Ptero_PosY, pt_off,
           Cactus_PosX, Cactus_PosY, Cactus_SizeX, Cactus_SizeY,
    output Dead, Hit_Type, Restart_Ready, Score, Hi_Score
  );
endinterface

// File: rtl/collision_detector.sv
// Per-frame hitbox overlap test with multi-frame hit confirmation, death hold timer,
// and running / high score keeping.
module collision_detector #(
  parameter int          DINO_W         = 88,
  parameter int          DINO_H         = 94,
  parameter int          PTERO_W        = 92,
  parameter int          PTERO_H        = 80,
  parameter int          HIT_MARGIN     = 8,
  parameter int unsigned CONFIRM_FRAMES = 2,
  parameter int unsigned DEATH_HOLD     = 30,
  parameter int unsigned SCORE_DIV      = 6
) (
  input logic                 frame_Clk,
  input logic                 Reset,
  collision_detector_if.slave bus
);

  localparam int unsigned DivW  = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int unsigned HoldW = $clog2(DEATH_HOLD + 1);

  localparam logic [DivW-1:0]  DivLast  = DivW'(SCORE_DIV - 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(DEATH_HOLD);
  localparam logic [4:0]       ConfirmN = 5'(CONFIRM_FRAMES);

  localparam logic signed [31:0] Margin = 32'(HIT_MARGIN);
  localparam logic signed [31:0] DinoW  = 32'(DINO_W);
  localparam logic signed [31:0] DinoH  = 32'(DINO_H);
  localparam logic signed [31:0] PteroW = 32'(PTERO_W);
  localparam logic signed [31:0] PteroH = 32'(PTERO_H);

  typedef enum logic [1:0] {StIdle, StRun, StPend, StDead} state_e;

  state_e state_q, state_d;

  logic [3:0]       hit_cnt_q;
  logic [DivW-1:0]  div_cnt_q;
  logic [HoldW-1:0] hold_cnt_q;
  logic [1:0]       hit_type_q;
  logic [15:0]      score_q, hi_score_q;

  // Margin-trimmed boxes; all arithmetic signed so off-screen (negative) X compares correctly.
  logic signed [31:0] dxlo, dxhi, dylo, dyhi;
  logic signed [31:0] pxlo, pxhi, pylo, pyhi;
  logic signed [31:0] cxlo, cxhi, cylo, cyhi;

  assign dxlo = bus.Dino_PosX + Margin;
  assign dxhi = bus.Dino_PosX + DinoW - Margin;
  assign dylo = bus.Dino_PosY + Margin;
  assign dyhi = bus.Dino_PosY + DinoH - Margin;
  assign pxlo = bus.Ptero_PosX + Margin;
  assign pxhi = bus.Ptero_PosX + PteroW - Margin;
  assign pylo = bus.Ptero_PosY + Margin;
  assign pyhi = bus.Ptero_PosY + PteroH - Margin;
  assign cxlo = bus.Cactus_PosX + Margin;
  assign cxhi = bus.Cactus_PosX + bus.Cactus_SizeX - Margin;
  assign cylo = bus.Cactus_PosY + Margin;
  assign cyhi = bus.Cactus_PosY + bus.Cactus_SizeY - Margin;

  logic ov_p, ov_c, ov;
  assign ov_p = !bus.pt_off && (dxlo < pxhi) && (pxlo < dxhi) && (dylo < pyhi) && (pylo < dyhi);
  assign ov_c = (bus.Cactus_SizeX > 32'sd0) &&
                (dxlo < cxhi) && (cxlo < dxhi) && (dylo < cyhi) && (cylo < dyhi);
  assign ov   = ov_p | ov_c;

  logic run_req, stop_req, hit_last, restart_ready;
  assign run_req       = (bus.Game_State == 2'b01);
  assign stop_req      = (bus.Game_State[1] == bus.Game_State[0]);
  assign hit_last      = (({1'b0, hit_cnt_q} + 5'd1) == ConfirmN);
  assign restart_ready = (state_q == StDead) && (hold_cnt_q == HoldMax);

  always_ff @(posedge frame_Clk or posedge Reset) begin
    if (Reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (run_req) state_d = StRun;
      StRun: begin
        if (!run_req)  state_d = StIdle;
        else if (ov)   state_d = (CONFIRM_FRAMES == 1) ? StDead : StPend;
      end
      StPend: begin
        if (!run_req)     state_d = StIdle;
        else if (!ov)     state_d = StRun;
        else if (hit_last) state_d = StDead;
      end
      StDead: if (stop_req && restart_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  logic start, advance, enter_dead;
  assign start      = (state_q == StIdle) && (state_d == StRun);
  assign enter_dead = (state_q != StDead) && (state_d == StDead);
  // Score ticks on frames that remain in play; the confirming (death) edge freezes it.
  assign advance    = ((state_q == StRun) && (state_d == StRun)) ||
                      ((state_q == StPend) && ((state_d == StRun) || (state_d == StPend)));

  always_ff @(posedge frame_Clk or posedge Reset) begin
    if (Reset) begin
      hit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      hold_cnt_q <= '0;
      hit_type_q <= 2'b00;
      score_q    <= '0;
      hi_score_q <= '0;
    end else begin
      if (start) begin
        score_q    <= '0;
        div_cnt_q  <= '0;
        hit_cnt_q  <= '0;
        hit_type_q <= 2'b00;
      end else if (advance) begin
        if (div_cnt_q == DivLast) begin
          div_cnt_q <= '0;
          if (score_q != 16'hFFFF) score_q <= score_q + 16'd1;
        end else begin
          div_cnt_q <= div_cnt_q + 1'b1;
        end
      end

      if ((state_q == StRun) && (state_d == StPend))       hit_cnt_q <= 4'd1;
      else if ((state_q == StPend) && (state_d == StPend)) hit_cnt_q <= hit_cnt_q + 4'd1;
      else if ((state_q == StPend) && (state_d == StRun))  hit_cnt_q <= 4'd0;

      if (enter_dead) begin
        hit_type_q <= {ov_p, ov_c};
        hold_cnt_q <= '0;
        if (score_q > hi_score_q) hi_score_q <= score_q;
      end else if ((state_q == StDead) && (hold_cnt_q != HoldMax)) begin
        hold_cnt_q <= hold_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    bus.Dead          = (state_q == StDead);
    bus.Restart_Ready = restart_ready;
    bus.Hit_Type      = hit_type_q;
    bus.Score         = score_q;
    bus.Hi_Score      = hi_score_q;
  end

endmodule
